// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
//   Generates CHANNELS independent divided clocks and single-cycle tick enables
//   from one system clock. Each channel has a runtime-programmable divisor
//   (0 is treated as 1), a run/stop enable, and a pending-divisor register.
//   A pending divisor is applied at the channel's next terminal count, or at
//   once while the channel is disabled. Reloading therefore never produces a
//   short or glitched output period.
//
//   Optional feature: define MULTI_CLOCK_DIVIDER_SYNC_START_EN to add the
//   sync_start input. It phase-aligns all channels on one edge.
//
// Parameters:
//   CHANNELS    - number of independent divider channels (>=1)
//   WIDTH       - divisor/counter width in bits (>=1)
//   DEFAULT_DIV - divisor loaded into every channel at reset (1..2^WIDTH-1)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   enable     in   [CHANNELS]       per-channel run enable
//   divisor    in   [CHANNELS*WIDTH] packed divisors, channel c at [c*WIDTH +: WIDTH]
//   load       in   [CHANNELS]       strobe capturing divisor[c] as pending
//   sync_start in   1                (optional) realign all channels
//   pending    out  [CHANNELS]       captured divisor not yet applied
//   tick       out  [CHANNELS]       one-cycle pulse at each terminal count
//   clk_out    out  [CHANNELS]       toggles at each terminal count
// -----------------------------------------------------------------------------
module multi_clock_divider #(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS*WIDTH-1:0] divisor,
   input  logic [CHANNELS-1:0]       load,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_START_EN
   input  logic                      sync_start,
`endif
   output logic [CHANNELS-1:0]       pending,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       clk_out
);

   localparam logic [WIDTH-1:0] LP_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] LP_ONE         = WIDTH'(1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] r_active_div;
      logic [WIDTH-1:0] r_pend_div;
      logic [WIDTH-1:0] r_cnt;
      logic             r_pending;
      logic             r_tick;
      logic             r_clk_out;

      logic [WIDTH-1:0] w_div_in;
      logic [WIDTH-1:0] w_load_div;
      logic [WIDTH-1:0] w_next_div;

      // Incoming divisor with 0 mapped to 1 so active_div is never 0
      assign w_div_in   = divisor[c*WIDTH +: WIDTH];
      assign w_load_div = (w_div_in == '0) ? LP_ONE : w_div_in;
      // Divisor to use at the next reload: a pending value wins over the active one
      assign w_next_div = r_pending ? r_pend_div : r_active_div;

      // Per-channel counter, pending-divisor handling and output registers
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_active_div <= LP_DEFAULT_DIV;
            r_cnt        <= LP_DEFAULT_DIV - LP_ONE;
            r_pend_div   <= '0;
            r_pending    <= 1'b0;
            r_tick       <= 1'b0;
            r_clk_out    <= 1'b0;
         end else begin
`ifdef MULTI_CLOCK_DIVIDER_SYNC_START_EN
            if (sync_start) begin
               // Realign: apply any pending value and restart a full period from low
               r_active_div <= w_next_div;
               r_cnt        <= w_next_div - LP_ONE;
               r_pending    <= 1'b0;
               r_tick       <= 1'b0;
               r_clk_out    <= 1'b0;
            end else
`endif
            if (enable[c]) begin
               if (r_cnt == '0) begin
                  r_tick    <= 1'b1;
                  r_clk_out <= ~r_clk_out;
                  r_cnt     <= w_next_div - LP_ONE;
                  if (r_pending) begin
                     r_active_div <= r_pend_div;
                     r_pending    <= 1'b0;
                  end
               end else begin
                  r_cnt  <= r_cnt - LP_ONE;
                  r_tick <= 1'b0;
               end
            end else begin
               r_tick <= 1'b0;
               // A stopped channel takes a pending divisor at once for a clean restart
               if (r_pending) begin
                  r_active_div <= r_pend_div;
                  r_cnt        <= r_pend_div - LP_ONE;
                  r_pending    <= 1'b0;
               end
            end

            // A load on this edge overrides any clear above; the new value
            // stays pending until the following terminal count
            if (load[c]) begin
               r_pend_div <= w_load_div;
               r_pending  <= 1'b1;
            end
         end
      end

      assign pending[c] = r_pending;
      assign tick[c]    = r_tick;
      assign clk_out[c] = r_clk_out;
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
//   Directed self-checking bench for multi_clock_divider with default
//   parameters (CHANNELS=2, WIDTH=8, DEFAULT_DIV=1). Outputs are sampled 1 time
//   unit after each rising edge. Inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

   logic        clock;
   logic        reset_n;
   logic [1:0]  enable;
   logic [15:0] divisor;
   logic [1:0]  load;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_START_EN
   logic        sync_start;
`endif
   logic [1:0]  pending;
   logic [1:0]  tick;
   logic [1:0]  clk_out;

   int checks   = 0;
   int failures = 0;

   logic exp_clk0;
   logic exp_clk1;
   logic exp_t;

   multi_clock_divider #(
      .CHANNELS    (2),
      .WIDTH       (8),
      .DEFAULT_DIV (1)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .divisor    (divisor),
      .load       (load),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_START_EN
      .sync_start (sync_start),
`endif
      .pending    (pending),
      .tick       (tick),
      .clk_out    (clk_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle before sampling
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      enable  = 2'b00;
      divisor = 16'h0000;
      load    = 2'b00;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_START_EN
      sync_start = 1'b0;
`endif
      // ---- reset state ----
      #3;
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_clk", 32'(clk_out), 32'h0);
      chk("rst_pend", 32'(pending), 32'h0);
      step();
      step();
      reset_n = 1'b1;
      enable  = 2'b11;

      // ---- DEFAULT_DIV=1: tick every edge, clk_out toggles every edge ----
      step();
      chk("d1_tick_e1", 32'(tick), 32'h3);
      chk("d1_clk_e1", 32'(clk_out), 32'h3);
      step();
      chk("d1_tick_e2", 32'(tick), 32'h3);
      chk("d1_clk_e2", 32'(clk_out), 32'h0);
      step();
      chk("d1_tick_e3", 32'(tick), 32'h3);
      chk("d1_clk_e3", 32'(clk_out), 32'h3);

      // ---- ch0 divisor 4 loaded while disabled ----
      enable  = 2'b00;
      divisor = 16'h0004;
      load    = 2'b01;
      step();
      chk("ld4_pend", 32'(pending), 32'h1);
      chk("ld4_tick", 32'(tick), 32'h0);
      load = 2'b00;
      step();
      chk("ld4_applied", 32'(pending), 32'h0);
      enable   = 2'b01;
      exp_clk0 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         exp_t = ((i % 4) == 0);
         if (exp_t) exp_clk0 = ~exp_clk0;
         chk($sformatf("d4_tick_e%0d", i), 32'(tick[0]), 32'(exp_t));
         chk($sformatf("d4_clk_e%0d", i), 32'(clk_out[0]), 32'(exp_clk0));
      end
      chk("d4_ch1_idle", 32'(tick[1]), 32'h0);

      // ---- load 6 mid-count: pending until next terminal, then spacing 6 ----
      divisor = 16'h0006;
      load    = 2'b01;
      step();
      chk("ld6_pend_e13", 32'(pending[0]), 32'h1);
      chk("ld6_tick_e13", 32'(tick[0]), 32'h0);
      load = 2'b00;
      step();
      chk("ld6_pend_e14", 32'(pending[0]), 32'h1);
      step();
      chk("ld6_pend_e15", 32'(pending[0]), 32'h1);
      chk("ld6_tick_e15", 32'(tick[0]), 32'h0);
      step();
      exp_clk0 = ~exp_clk0;
      chk("ld6_tick_e16", 32'(tick[0]), 32'h1);
      chk("ld6_pend_e16", 32'(pending[0]), 32'h0);
      for (int i = 17; i <= 28; i++) begin
         step();
         exp_t = (i == 22) || (i == 28);
         if (exp_t) exp_clk0 = ~exp_clk0;
         chk($sformatf("d6_tick_e%0d", i), 32'(tick[0]), 32'(exp_t));
      end
      chk("d6_clk_e28", 32'(clk_out[0]), 32'(exp_clk0));

      // ---- zero divisor on ch1 behaves as divisor 1 ----
      enable  = 2'b00;
      divisor = 16'h0000;
      load    = 2'b10;
      step();
      chk("ld0_pend", 32'(pending), 32'h2);
      load = 2'b00;
      step();
      chk("ld0_applied", 32'(pending), 32'h0);
      enable   = 2'b10;
      exp_clk1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         exp_clk1 = ~exp_clk1;
         chk($sformatf("z_tick_e%0d", i), 32'(tick[1]), 32'h1);
         chk($sformatf("z_clk_e%0d", i), 32'(clk_out[1]), 32'(exp_clk1));
      end

      // ---- disable/hold with ch0 divisor 5 ----
      enable  = 2'b00;
      divisor = 16'h0005;
      load    = 2'b01;
      step();
      load = 2'b00;
      step();
      enable = 2'b01;
      step();
      chk("hold_pre_e1", 32'(tick[0]), 32'h0);
      step();
      chk("hold_pre_e2", 32'(tick[0]), 32'h0);
      enable = 2'b00;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("hold_tick_c%0d", i), 32'(tick[0]), 32'h0);
         chk($sformatf("hold_clk_c%0d", i), 32'(clk_out[0]), 32'(exp_clk0));
      end
      enable = 2'b01;
      step();
      chk("resume_e1", 32'(tick[0]), 32'h0);
      step();
      chk("resume_e2", 32'(tick[0]), 32'h0);
      step();
      exp_clk0 = ~exp_clk0;
      chk("resume_e3_tick", 32'(tick[0]), 32'h1);
      chk("resume_e3_clk", 32'(clk_out[0]), 32'(exp_clk0));

      // ---- load 7 coincident with terminal of divisor 3 ----
      enable  = 2'b00;
      divisor = 16'h0003;
      load    = 2'b01;
      step();
      load = 2'b00;
      step();
      enable = 2'b01;
      step();
      chk("coin_e1", 32'(tick[0]), 32'h0);
      step();
      chk("coin_e2", 32'(tick[0]), 32'h0);
      divisor = 16'h0007;
      load    = 2'b01;
      step();
      chk("coin_e3_tick", 32'(tick[0]), 32'h1);
      chk("coin_e3_pend", 32'(pending[0]), 32'h1);
      load = 2'b00;
      for (int i = 4; i <= 13; i++) begin
         step();
         exp_t = (i == 6) || (i == 13);
         chk($sformatf("coin_tick_e%0d", i), 32'(tick[0]), 32'(exp_t));
         chk($sformatf("coin_pend_e%0d", i), 32'(pending[0]), 32'(i < 6));
      end

      // ---- async reset mid-count with a pending load ----
      enable  = 2'b11;
      divisor = 16'h0009;
      load    = 2'b01;
      step();
      chk("ar_pre_pend", 32'(pending), 32'h1);
      chk("ar_pre_tick", 32'(tick), 32'h2);
      load = 2'b00;
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_tick", 32'(tick), 32'h0);
      chk("ar_pend", 32'(pending), 32'h0);
      chk("ar_clk", 32'(clk_out), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      step();
      chk("ar_post_tick_e1", 32'(tick), 32'h3);
      chk("ar_post_clk_e1", 32'(clk_out), 32'h3);
      step();
      chk("ar_post_tick_e2", 32'(tick), 32'h3);
      chk("ar_post_clk_e2", 32'(clk_out), 32'h0);

`ifdef MULTI_CLOCK_DIVIDER_SYNC_START_EN
      // ---- sync_start phase-aligns ch0=4 and ch1=8 ----
      enable  = 2'b00;
      divisor = {8'd8, 8'd4};
      load    = 2'b11;
      step();
      load = 2'b00;
      step();
      enable = 2'b01;
      step();
      step();
      enable = 2'b11;
      step();
      step();
      step();
      sync_start = 1'b1;
      step();
      chk("sync_clk", 32'(clk_out), 32'h0);
      chk("sync_tick", 32'(tick), 32'h0);
      sync_start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk($sformatf("sync_tick_e%0d", i), 32'(tick),
             32'({(i == 8), ((i % 4) == 0)}));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
